// File: rtl/div_issue_ctrl.sv
// Issue-side controller for the divider: accepts one op over valid/ready, drives the
// divider enable/completed protocol, and returns the tagged quotient to writeback.
module div_issue_ctrl #(
  parameter int          TAG_W          = 5,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] DZ_RESULT      = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      div_a,
  output logic [31:0]      div_b,
  output logic             div_enabled,
  input  logic [31:0]      div_c,
  input  logic             div_completed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dz,
  output logic             out_timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    OUT
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [31:0]      a_nx, b_nx, data_nx;
  logic [TAG_W-1:0] tag_nx;
  logic             en_nx, valid_nx, dz_nx, timeout_nx;
  logic             accept;

  // Held off during reset so dispatch never sees a handshake that is about to be discarded.
  assign in_ready = rstn && (state == IDLE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: every target gets a hold-value default first, so no path can infer a latch.
    state_nx   = state;
    cnt_nx     = cnt;
    a_nx       = div_a;
    b_nx       = div_b;
    tag_nx     = out_tag;
    data_nx    = out_data;
    en_nx      = div_enabled;
    valid_nx   = out_valid;
    dz_nx      = out_dz;
    timeout_nx = out_timeout;

    case (state)
      IDLE: begin
        if (accept) begin
          a_nx       = in_a;
          b_nx       = in_b;
          tag_nx     = in_tag;
          timeout_nx = 1'b0;
          if (in_b == '0) begin
            // Zero divisor never reaches the divider; the result is known immediately.
            state_nx = OUT;
            data_nx  = DZ_RESULT;
            dz_nx    = 1'b1;
            valid_nx = 1'b1;
          end else begin
            state_nx = RUN;
            en_nx    = 1'b1;
            cnt_nx   = '0;
            dz_nx    = 1'b0;
          end
        end
      end

      RUN: begin
        cnt_nx = cnt + 1'b1;
        // Completion is checked first so a result arriving on the last allowed cycle is kept.
        if (div_completed) begin
          data_nx  = div_c;
          en_nx    = 1'b0;
          valid_nx = 1'b1;
          state_nx = OUT;
        end else if (cnt == CNT_LAST) begin
          data_nx    = '0;
          timeout_nx = 1'b1;
          en_nx      = 1'b0;
          valid_nx   = 1'b1;
          state_nx   = OUT;
        end
      end

      OUT: begin
        if (out_ready) begin
          valid_nx = 1'b0;
          state_nx = IDLE;
        end
      end

      default: begin
        state_nx = IDLE;
        en_nx    = 1'b0;
        valid_nx = 1'b0;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      div_a       <= '0;
      div_b       <= '0;
      out_tag     <= '0;
      out_data    <= '0;
      div_enabled <= 1'b0;
      out_valid   <= 1'b0;
      out_dz      <= 1'b0;
      out_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      div_a       <= a_nx;
      div_b       <= b_nx;
      out_tag     <= tag_nx;
      out_data    <= data_nx;
      div_enabled <= en_nx;
      out_valid   <= valid_nx;
      out_dz      <= dz_nx;
      out_timeout <= timeout_nx;
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl with a fixed-latency stub divider.
module tb_div_issue_ctrl;

  localparam int TAG_W          = 5;
  localparam int TIMEOUT_CYCLES = 64;
  localparam int STUB_LAT       = 5;

  logic             clk = 1'b0;
  logic             rstn;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a, in_b;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      div_a, div_b, div_c;
  logic             div_enabled, div_completed;
  logic             out_valid, out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_dz, out_timeout;

  div_issue_ctrl #(
    .TAG_W(TAG_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .DZ_RESULT(32'hFFFF_FFFF)
  ) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .div_a(div_a), .div_b(div_b), .div_enabled(div_enabled),
    .div_c(div_c), .div_completed(div_completed),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag),
    .out_dz(out_dz), .out_timeout(out_timeout)
  );

  always #5 clk = ~clk;

  // Stub divider: completes STUB_LAT enabled cycles after enable, unless hang is set.
  int   en_cnt = 0;
  logic hang   = 1'b0;
  always @(posedge clk) begin
    if (!div_enabled) en_cnt <= 0;
    else              en_cnt <= en_cnt + 1;
  end
  assign div_completed = div_enabled && !hang && (en_cnt >= STUB_LAT - 1);
  assign div_c         = (div_b == 0) ? 32'd0 : div_a / div_b;

  // Tracks enable low-time between divider ops.
  int low_run = 0;
  bit had_op  = 1'b0;
  int gap_err = 0;
  always @(negedge clk) begin
    if (div_enabled) begin
      if (had_op && low_run > 0 && low_run < 2) gap_err++;
      had_op  = 1'b1;
      low_run = 0;
    end else begin
      low_run++;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_out(input string name);
    int g = 0;
    while (!out_valid && g < 200) begin
      @(negedge clk);
      g++;
    end
    check(name, out_valid, 1'b1);
  endtask

  typedef struct {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    logic             hang;
    logic [31:0]      exp_data;
    logic             exp_dz;
    logic             exp_to;
    int               exp_lat;
    int               exp_en;
  } vec_t;

  // Drives one op with out_ready high, measures latency and enable cycles, checks the result.
  task automatic run_op(input vec_t v, input int idx);
    int   lat;
    int   en;
    logic hold_ok;
    @(negedge clk);
    hang = v.hang;
    check($sformatf("v%0d in_ready", idx), in_ready, 1'b1);
    in_valid = 1'b1;
    in_a     = v.a;
    in_b     = v.b;
    in_tag   = v.tag;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat     = 1;
    en      = 0;
    hold_ok = 1'b1;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      if (div_enabled) begin
        en++;
        if (div_a !== v.a || div_b !== v.b) hold_ok = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    check($sformatf("v%0d out_valid", idx), out_valid, 1'b1);
    check($sformatf("v%0d out_data", idx), out_data, v.exp_data);
    check($sformatf("v%0d out_tag", idx), 32'(out_tag), 32'(v.tag));
    check($sformatf("v%0d out_dz", idx), out_dz, v.exp_dz);
    check($sformatf("v%0d out_timeout", idx), out_timeout, v.exp_to);
    check($sformatf("v%0d latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d enable_cycles", idx), en, v.exp_en);
    check($sformatf("v%0d operands_stable", idx), hold_ok, 1'b1);
    check($sformatf("v%0d enable_low_at_out", idx), div_enabled, 1'b0);
    @(posedge clk);
  endtask

  vec_t vecs[7];
  logic hold_ok;

  initial begin
    vecs[0] = '{32'd100,        32'd7,  5'd3,  1'b0, 32'd14,         1'b0, 1'b0, 6,  5};
    vecs[1] = '{32'd42,         32'd0,  5'd9,  1'b0, 32'hFFFF_FFFF,  1'b1, 1'b0, 1,  0};
    vecs[2] = '{32'd0,          32'd5,  5'd31, 1'b0, 32'd0,          1'b0, 1'b0, 6,  5};
    vecs[3] = '{32'hFFFF_FFFF,  32'd1,  5'd0,  1'b0, 32'hFFFF_FFFF,  1'b0, 1'b0, 6,  5};
    vecs[4] = '{32'd1000,       32'd10, 5'd17, 1'b1, 32'd0,          1'b0, 1'b1, 65, 64};
    vecs[5] = '{32'd77,         32'd7,  5'd4,  1'b0, 32'd11,         1'b0, 1'b0, 6,  5};
    vecs[6] = '{32'd5,          32'd0,  5'd30, 1'b0, 32'hFFFF_FFFF,  1'b1, 1'b0, 1,  0};

    // Reset with a pending op: nothing is accepted.
    rstn      = 1'b0;
    in_valid  = 1'b1;
    in_a      = 32'd1;
    in_b      = 32'd1;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("reset in_ready", in_ready, 1'b0);
    end
    rstn     = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("post-reset out_valid", out_valid, 1'b0);
    check("post-reset div_enabled", div_enabled, 1'b0);
    check("post-reset in_ready", in_ready, 1'b1);
    check("post-reset out_data", out_data, 32'd0);
    check("post-reset div_a", div_a, 32'd0);

    for (int i = 0; i < 7; i++) run_op(vecs[i], i);

    // Back-pressure with a second op offered continuously behind the first.
    @(negedge clk);
    hang      = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 32'd84;
    in_b      = 32'd4;
    in_tag    = 5'd1;
    @(posedge clk);
    #1;
    in_a   = 32'd9;
    in_b   = 32'd3;
    in_tag = 5'd2;
    wait_out("bp first out_valid");
    check("bp first data", out_data, 32'd21);
    check("bp first tag", 32'(out_tag), 32'd1);
    hold_ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!out_valid || out_data !== 32'd21 || out_tag !== 5'd1 || in_ready) hold_ok = 1'b0;
    end
    check("bp result held, in_ready low", hold_ok, 1'b1);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp after handshake out_valid", out_valid, 1'b0);
    check("bp after handshake in_ready", in_ready, 1'b1);
    check("bp enable gap", div_enabled, 1'b0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out("bp second out_valid");
    check("bp second data", out_data, 32'd3);
    check("bp second tag", 32'(out_tag), 32'd2);
    @(posedge clk);

    // Reset in the middle of RUN aborts the op silently.
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = 32'd500;
    in_b     = 32'd5;
    in_tag   = 5'd7;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid-run enabled before reset", div_enabled, 1'b1);
    rstn = 1'b0;
    @(negedge clk);
    check("mid-run reset div_enabled", div_enabled, 1'b0);
    check("mid-run reset out_valid", out_valid, 1'b0);
    rstn = 1'b1;
    run_op('{32'd50, 32'd5, 5'd12, 1'b0, 32'd10, 1'b0, 1'b0, 6, 5}, 7);

    check("enable gap violations", gap_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
